// File: rtl/jump_issue_ctrl_pkg.sv
// Shared types for the jump/branch issue controller: FSM states, comparator
// selects and the latched op payload.
package jump_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Comparator selects follow the RISC-V branch funct3 encoding.
    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BGE  = 3'b101;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic [2:0] CMP_BGEU = 3'b111;

    // Payload tag storage is sized for the widest supported TAG_W.
    localparam int OP_TAG_W = 8;

    typedef struct packed {
        logic                uncond;
        logic                jalr;
        logic [2:0]          cmp_ctrl;
        logic [31:0]         rs1;
        logic [31:0]         rs2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic [OP_TAG_W-1:0] tag;
    } op_t;

endpackage

// File: rtl/jump_issue_arb.sv
// Two-way request arbiter. With JUMP_ISSUE_RR_EN defined it alternates priority
// after each grant; otherwise requester 0 always wins and no state is kept.
module jump_issue_arb (
`ifdef JUMP_ISSUE_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

`ifdef JUMP_ISSUE_RR_EN
    logic prio_r;  // 0: requester 0 has priority

    // Grant selection honouring the current priority pointer
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en) begin
            if (prio_r == 1'b0) begin
                grant0 = valid0;
                grant1 = valid1 & ~valid0;
            end else begin
                grant1 = valid1;
                grant0 = valid0 & ~valid1;
            end
        end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    // Priority pointer passes to the other requester after each grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (grant0) begin
            prio_r <= 1'b1;
        end else if (grant1) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end
`else
    // Fixed priority grant selection
    always_comb begin
        grant0 = en & valid0;
        grant1 = en & valid1 & ~valid0;
    end
`endif

endmodule

// File: rtl/jump_issue_ctrl.sv
// Issue controller for a single-op jump/branch unit: arbitrates two requesters,
// sequences IDLE/ISSUE/WAIT/DONE and holds the result. Option: JUMP_ISSUE_RR_EN.
module jump_issue_ctrl
    import jump_issue_ctrl_pkg::*;
#(
    parameter int TAG_W = 4  // must not exceed OP_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_uncond,
    input  logic             req0_jalr,
    input  logic [2:0]       req0_cmp_ctrl,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,
    input  logic [31:0]      req0_imm,
    input  logic [31:0]      req0_pc,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_uncond,
    input  logic             req1_jalr,
    input  logic [2:0]       req1_cmp_ctrl,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,
    input  logic [31:0]      req1_imm,
    input  logic [31:0]      req1_pc,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             fu_en,
    output logic             fu_jalr,
    output logic [2:0]       fu_cmp_ctrl,
    output logic [31:0]      fu_rs1,
    output logic [31:0]      fu_rs2,
    output logic [31:0]      fu_imm,
    output logic [31:0]      fu_pc,
    input  logic             fu_finish,
    input  logic             fu_cmp_res,
    input  logic [31:0]      fu_pc_jump,
    input  logic [31:0]      fu_pc_wb,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_taken,
    output logic [31:0]      wb_target,
    output logic [31:0]      wb_link,
    input  logic             flush,
    output logic             busy
);

    state_e            state_r, next_state_s;
    op_t               op_r, req_op_s;
    logic              grant0_s, grant1_s, arb_en_s, accept_s, capture_s;
    logic              fu_en_r, wb_valid_r, busy_r, wb_taken_r;
    logic [31:0]       wb_target_r, wb_link_r;
    logic [TAG_W-1:0]  wb_tag_r;

    // Grants only while idle and not being flushed, so a flush blocks accepts.
    assign arb_en_s = (state_r == ST_IDLE) && !flush;
    assign accept_s = grant0_s | grant1_s;

    jump_issue_arb u_arb (
`ifdef JUMP_ISSUE_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .en     (arb_en_s),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0_s),
        .grant1 (grant1_s)
    );

    // Payload of the granted requester
    always_comb begin
        if (grant1_s) begin
            req_op_s = '{uncond: req1_uncond, jalr: req1_jalr, cmp_ctrl: req1_cmp_ctrl,
                         rs1: req1_rs1, rs2: req1_rs2, imm: req1_imm, pc: req1_pc,
                         tag: OP_TAG_W'(req1_tag)};
        end else begin
            req_op_s = '{uncond: req0_uncond, jalr: req0_jalr, cmp_ctrl: req0_cmp_ctrl,
                         rs1: req0_rs1, rs2: req0_rs2, imm: req0_imm, pc: req0_pc,
                         tag: OP_TAG_W'(req0_tag)};
        end
    end

    // Next-state logic; flush forces IDLE and suppresses result capture
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        if (flush) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) next_state_s = ST_ISSUE;
                    else          next_state_s = ST_IDLE;
                end
                ST_ISSUE: next_state_s = ST_WAIT;
                ST_WAIT: begin
                    if (fu_finish) begin
                        next_state_s = ST_DONE;
                        capture_s    = 1'b1;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (wb_ready) next_state_s = ST_IDLE;
                    else          next_state_s = ST_DONE;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State, operand latch and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            fu_en_r     <= 1'b0;
            wb_valid_r  <= 1'b0;
            op_r        <= '0;
            wb_taken_r  <= 1'b0;
            wb_target_r <= 32'd0;
            wb_link_r   <= 32'd0;
            wb_tag_r    <= '0;
        end else begin
            state_r    <= next_state_s;
            busy_r     <= (next_state_s != ST_IDLE);
            fu_en_r    <= accept_s;
            wb_valid_r <= (next_state_s == ST_DONE);
            if (accept_s) begin
                op_r <= req_op_s;
            end
            if (capture_s) begin
                wb_taken_r  <= op_r.uncond | fu_cmp_res;
                wb_target_r <= fu_pc_jump;
                wb_link_r   <= fu_pc_wb;
                wb_tag_r    <= op_r.tag[TAG_W-1:0];
            end
        end
    end

    generate
        if (TAG_W < OP_TAG_W) begin : g_tag_pad
            logic unused_tag_pad_s;
            assign unused_tag_pad_s = ^op_r.tag[OP_TAG_W-1:TAG_W];
        end
    endgenerate

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign fu_en       = fu_en_r;
    assign fu_jalr     = op_r.jalr;
    assign fu_cmp_ctrl = op_r.cmp_ctrl;
    assign fu_rs1      = op_r.rs1;
    assign fu_rs2      = op_r.rs2;
    assign fu_imm      = op_r.imm;
    assign fu_pc       = op_r.pc;
    assign wb_valid    = wb_valid_r;
    assign wb_tag      = wb_tag_r;
    assign wb_taken    = wb_taken_r;
    assign wb_target   = wb_target_r;
    assign wb_link     = wb_link_r;
    assign busy        = busy_r;

endmodule
